// File: rtl/add_seq_pkg.sv
// Shared types and constants for the load/add/display sequencer.
package add_seq_pkg;

  localparam int DWELL_W_DEF = 4;
  localparam int PHASE_W_DEF = 2;

  localparam logic [1:0] PH_BLANK = 2'b00;
  localparam logic [1:0] PH_A     = 2'b01;
  localparam logic [1:0] PH_B     = 2'b10;
  localparam logic [1:0] PH_SUM   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHOW_A,
    ST_SHOW_B,
    ST_SHOW_SUM,
    ST_DONE
  } state_t;

  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      ST_SHOW_A:   return PH_A;
      ST_SHOW_B:   return PH_B;
      ST_SHOW_SUM: return PH_SUM;
      default:     return PH_BLANK;
    endcase
  endfunction

  function automatic logic is_show(input state_t s);
    return (s == ST_SHOW_A) || (s == ST_SHOW_B) || (s == ST_SHOW_SUM);
  endfunction

endpackage

// File: rtl/add_seq_controller_dwell_timer.sv
// Loadable down-counter with hold; expired is high on the last cycle of a dwell.
module dwell_timer #(
  parameter int W = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         load,
  input  logic         hold,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = load_val;
    else if (hold)          cnt_d = cnt_q;
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = (cnt_q <= W'(1));

endmodule

// File: rtl/add_seq_controller.sv
// Sequencer for the 8-bit load/add/display datapath.
// Optional auto-repeat input Repeat is enabled by defining ADD_SEQ_AUTO_REPEAT_EN.
module add_seq_controller
  import add_seq_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF
) (
  input  logic               Clock,
  input  logic               Reset,
`ifdef ADD_SEQ_AUTO_REPEAT_EN
  input  logic               Repeat,
`endif
  input  logic               Start,
  input  logic               Abort,
  input  logic               Hold,
  input  logic [DWELL_W-1:0] Dwell,
  output logic [PHASE_W-1:0] Counter,
  output logic               Load,
  output logic               Busy,
  output logic               Done,
  output logic               Disp_valid
);

  state_t               state_q, state_d;
  logic [DWELL_W-1:0]   dwell_cap_q, dwell_cap_d;
  logic [PHASE_W-1:0]   counter_q, counter_d;
  logic                 load_q, load_d, busy_q, busy_d, done_q, done_d;
  logic                 disp_valid_q, disp_valid_d;
  logic                 timer_load, timer_hold, timer_expired;
  logic                 go_again;

`ifdef ADD_SEQ_AUTO_REPEAT_EN
  logic repeat_q, repeat_d;

  // Repeat is sampled on the final SHOW_SUM cycle and remembered through DONE.
  always_comb begin
    repeat_d = 1'b0;
    if (state_d == ST_DONE)
      repeat_d = (state_q == ST_SHOW_SUM) ? Repeat : repeat_q;
  end

  always_ff @(posedge Clock) begin
    if (Reset) repeat_q <= 1'b0;
    else       repeat_q <= repeat_d;
  end

  assign go_again = repeat_q;
`else
  assign go_again = 1'b0;
`endif

  // Next-state logic: Abort beats Hold, Hold beats normal progress.
  always_comb begin
    state_d = state_q;
    if (state_q != ST_IDLE && Abort) begin
      state_d = ST_IDLE;
    end else if (state_q != ST_IDLE && Hold) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_IDLE:     if (Start && !Abort) state_d = ST_LOAD;
        ST_LOAD:     state_d = ST_SHOW_A;
        ST_SHOW_A:   if (timer_expired) state_d = ST_SHOW_B;
        ST_SHOW_B:   if (timer_expired) state_d = ST_SHOW_SUM;
        ST_SHOW_SUM: if (timer_expired) state_d = ST_DONE;
        ST_DONE:     state_d = go_again ? ST_LOAD : ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dwell_cap_d = dwell_cap_q;
    if (state_d == ST_LOAD && state_q != ST_LOAD)
      dwell_cap_d = (Dwell == '0) ? DWELL_W'(1) : Dwell;
  end

  assign timer_load = is_show(state_d) && (state_d != state_q);
  assign timer_hold = (state_q != ST_IDLE) && Hold && !Abort;

  dwell_timer #(.W(DWELL_W)) u_dwell_timer (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (timer_load),
    .hold     (timer_hold),
    .load_val (dwell_cap_q),
    .expired  (timer_expired)
  );

  // Outputs are decoded from the next state so the registered copies line up with the state.
  always_comb begin
    counter_d    = PHASE_W'(phase_of(state_d));
    load_d       = (state_d == ST_LOAD);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE) && (state_q != ST_DONE);
    disp_valid_d = (counter_q != '0);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      dwell_cap_q  <= DWELL_W'(1);
      counter_q    <= '0;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dwell_cap_q  <= dwell_cap_d;
      counter_q    <= counter_d;
      load_q       <= load_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  assign Counter    = counter_q;
  assign Load       = load_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Disp_valid = disp_valid_q;

endmodule

// File: tb/tb_add_seq_controller.sv
// Directed bench for add_seq_controller with a small registered load/add/display datapath model.
module tb_add_seq_controller;

  logic       Clock = 1'b0;
  logic       Reset, Start, Abort, Hold;
  logic [3:0] Dwell;
  logic [1:0] Counter;
  logic       Load, Busy, Done, Disp_valid;
`ifdef ADD_SEQ_AUTO_REPEAT_EN
  logic       Repeat = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [7:0]  a_in, b_in, a_q, b_q;
  logic [8:0]  sum_q;
  logic [15:0] data_out;

  add_seq_controller dut (
    .Clock      (Clock),
    .Reset      (Reset),
`ifdef ADD_SEQ_AUTO_REPEAT_EN
    .Repeat     (Repeat),
`endif
    .Start      (Start),
    .Abort      (Abort),
    .Hold       (Hold),
    .Dwell      (Dwell),
    .Counter    (Counter),
    .Load       (Load),
    .Busy       (Busy),
    .Done       (Done),
    .Disp_valid (Disp_valid)
  );

  always #5 Clock = ~Clock;

  // Datapath: A/B registers, registered sum, registered output mux.
  always @(posedge Clock) begin
    if (Load) begin
      a_q <= a_in;
      b_q <= b_in;
    end
    sum_q <= {1'b0, a_q} + {1'b0, b_q};
    case (Counter)
      2'b01:   data_out <= {8'h00, a_q};
      2'b10:   data_out <= {8'h00, b_q};
      2'b11:   data_out <= {7'h00, sum_q};
      default: data_out <= 16'h0000;
    endcase
  end

  always @(posedge Clock) if (Done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One full pass: dwell_in is driven, dw is the effective dwell the bench expects.
  task automatic run_pass(input logic [3:0] dwell_in, input int dw,
                          input logic [7:0] a, input logic [7:0] b, input logic [15:0] s);
    logic [15:0] shown [3];
    int d0;
    shown[0] = {8'h00, a};
    shown[1] = {8'h00, b};
    shown[2] = s;
    d0 = done_cnt;
    a_in = a; b_in = b; Dwell = dwell_in; Start = 1'b1;
    tick();
    Start = 1'b0;
    check("load_strobe", Load, 1);
    check("load_busy", Busy, 1);
    check("load_counter", Counter, 0);
    for (int i = 0; i < 3 * dw; i++) begin
      tick();
      check($sformatf("counter_%0d", i), Counter, i / dw + 1);
      check($sformatf("load_low_%0d", i), Load, 0);
      check($sformatf("dv_%0d", i), Disp_valid, i != 0);
      if (i > 0) check($sformatf("data_%0d", i), data_out, shown[(i - 1) / dw]);
    end
    tick();
    check("done_pulse", Done, 1);
    check("done_counter", Counter, 0);
    check("done_busy", Busy, 1);
    check("done_dv", Disp_valid, 1);
    check("done_data", data_out, s);
    tick();
    check("idle_done", Done, 0);
    check("idle_busy", Busy, 0);
    check("idle_dv", Disp_valid, 0);
    check("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; Hold = 1'b0; Dwell = 4'd0;
    a_in = 8'h00; b_in = 8'h00;
    tick(); tick();
    Reset = 1'b0;
    check("rst_counter", Counter, 0);
    check("rst_load", Load, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_dv", Disp_valid, 0);

    // Basic pass and minimum dwell with carry into bit 8.
    run_pass(4'd3, 3, 8'h12, 8'h34, 16'h0046);
    run_pass(4'd0, 1, 8'hFF, 8'h01, 16'h0100);

    // Hold for 4 cycles inside SHOW_B with dwell 2: Counter=10 for 6 cycles.
    d0 = done_cnt;
    Dwell = 4'd2; Start = 1'b1;
    tick(); Start = 1'b0;
    tick(); tick(); tick();
    check("hold_enter_b", Counter, 2);
    Hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("hold_b_%0d", i), Counter, 2);
    end
    Hold = 1'b0;
    tick();
    check("hold_b_last", Counter, 2);
    tick();
    check("hold_sum0", Counter, 3);
    tick();
    check("hold_sum1", Counter, 3);
    tick();
    check("hold_done", Done, 1);
    tick(); tick();
    check("hold_single_done", done_cnt - d0, 1);

    // Abort during SHOW_A, then a clean pass two cycles later.
    d0 = done_cnt;
    Dwell = 4'd3; Start = 1'b1;
    tick(); Start = 1'b0;
    tick();
    check("abort_in_a", Counter, 1);
    Abort = 1'b1;
    tick(); Abort = 1'b0;
    check("abort_counter", Counter, 0);
    check("abort_busy", Busy, 0);
    check("abort_load", Load, 0);
    tick(); tick();
    check("abort_no_done", done_cnt - d0, 0);
    run_pass(4'd2, 2, 8'h05, 8'h07, 16'h000C);

    // Start during SHOW_SUM is ignored; Start with Abort in IDLE is ignored.
    d0 = done_cnt;
    Dwell = 4'd1; Start = 1'b1;
    tick(); Start = 1'b0;
    tick(); tick(); tick();
    check("ign_in_sum", Counter, 3);
    Start = 1'b1;
    tick(); Start = 1'b0;
    check("ign_done", Done, 1);
    tick();
    check("ign_idle_busy", Busy, 0);
    tick();
    check("ign_no_rerun_load", Load, 0);
    check("ign_no_rerun_busy", Busy, 0);
    Start = 1'b1; Abort = 1'b1;
    tick(); Start = 1'b0; Abort = 1'b0;
    check("start_abort_load", Load, 0);
    check("start_abort_busy", Busy, 0);
    tick();
    check("ign_done_count", done_cnt - d0, 1);

    // Reset during LOAD.
    Dwell = 4'd2; Start = 1'b1;
    tick(); Start = 1'b0;
    check("pre_rst_load", Load, 1);
    Reset = 1'b1;
    tick(); Reset = 1'b0;
    check("midrst_load", Load, 0);
    check("midrst_busy", Busy, 0);
    check("midrst_counter", Counter, 0);
    check("midrst_done", Done, 0);
    check("midrst_dv", Disp_valid, 0);
    tick();
    check("midrst_stay_idle", Busy, 0);

`ifdef ADD_SEQ_AUTO_REPEAT_EN
    // Auto-repeat: Load re-asserts one cycle after Done.
    d0 = done_cnt;
    Dwell = 4'd1; Start = 1'b1;
    tick(); Start = 1'b0;
    tick(); tick(); tick();
    Repeat = 1'b1;
    tick(); Repeat = 1'b0;
    check("rep_done1", Done, 1);
    check("rep_busy1", Busy, 1);
    tick();
    check("rep_reload", Load, 1);
    check("rep_busy2", Busy, 1);
    tick(); tick(); tick(); tick();
    check("rep_done2", Done, 1);
    tick();
    check("rep_idle", Busy, 0);
    check("rep_two_dones", done_cnt - d0, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
